// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one add/shift step per clock, W steps per product.
// Optional build macro MULT_ZERO_SKIP_EN: zero operands bypass RUN and complete in one cycle.
module shift_add_multiplier #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    m_q, m_nx;
  logic [W-1:0]    q_q, q_nx;
  logic [W:0]      acc_q, acc_nx;
  logic [W:0]      sum;
  logic [CW-1:0]   cnt_q, cnt_nx;
  logic [2*W-1:0]  p_nx;
  logic            zero_skip;

  // Zero-operand shortcut decode; constant low when the feature is not built
`ifdef MULT_ZERO_SKIP_EN
  assign zero_skip = (a == '0) || (b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // Next-state and datapath step
  always_comb begin
    state_nx = state;
    m_nx     = m_q;
    q_nx     = q_q;
    acc_nx   = acc_q;
    cnt_nx   = cnt_q;
    p_nx     = p;
    sum      = q_q[0] ? (acc_q + {1'b0, m_q}) : acc_q;

    case (state)
      IDLE: begin
        if (start) begin
          if (zero_skip) begin
            p_nx     = '0;
            state_nx = DONE;
          end else begin
            m_nx     = a;
            q_nx     = b;
            acc_nx   = '0;
            cnt_nx   = '0;
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        // Carry lives in acc MSB; its LSB shifts into the multiplier register
        acc_nx = sum >> 1;
        q_nx   = {sum[0], q_q[W-1:1]};
        cnt_nx = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          p_nx     = {acc_nx[W-1:0], q_nx};
          state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      p     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      m_q   <= m_nx;
      q_q   <= q_nx;
      acc_q <= acc_nx;
      cnt_q <= cnt_nx;
      p     <= p_nx;
      busy  <= (state_nx == RUN);
      done  <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: W=4 scenarios plus a W=8 back-to-back stream.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_p4;

  always #5 clk = ~clk;

  shift_add_multiplier #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  shift_add_multiplier #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  // Full W=4 operation: busy for 4 cycles with p stable, then one done cycle
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v, input logic [7:0] ep, input string nm);
    @(negedge clk); start4 = 1'b1; a4 = ta; b4 = tb_v;
    @(negedge clk); start4 = 1'b0; a4 = ~ta; b4 = ~tb_v;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (busy4 !== 1'b1 || done4 !== 1'b0) begin
        n_bad++;
        $display("FAIL %s run k=%0d: busy=%b done=%b, required busy=1 done=0", nm, k, busy4, done4);
      end
      n_cmp++;
      if (p4 !== last_p4) begin
        n_bad++;
        $display("FAIL %s p_stable k=%0d: p=%0d, required %0d", nm, k, p4, last_p4);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || p4 !== ep) begin
      n_bad++;
      $display("FAIL %s complete: done=%b busy=%b p=%0d, required done=1 busy=0 p=%0d", nm, done4, busy4, p4, ep);
    end
    last_p4 = ep;
    @(negedge clk);
    n_cmp++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after: done=%b busy=%b, required 0 0", nm, done4, busy4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    last_p4 = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'd0 || busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'd0) begin
      n_bad++;
      $display("FAIL reset: busy4=%b done4=%b p4=%0d busy8=%b done8=%b p8=%0d, required all 0",
               busy4, done4, p4, busy8, done8, p8);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'd0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b p=%0d, required 0 0 0", busy4, done4, p4);
    end
  endtask

  task automatic test_max_and_hold();
    op4(4'd15, 4'd15, 8'd225, "max15x15");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (p4 !== 8'd225 || done4 !== 1'b0) begin
        n_bad++;
        $display("FAIL hold i=%0d: p=%0d done=%b, required p=225 done=0", i, p4, done4);
      end
    end
  endtask

  task automatic test_patterns();
    op4(4'd13, 4'd11, 8'd143, "13x11");
    op4(4'd1,  4'd9,  8'd9,   "1x9");
    op4(4'd8,  4'd2,  8'd16,  "8x2");
  endtask

  task automatic test_zero();
`ifdef MULT_ZERO_SKIP_EN
    @(negedge clk); start4 = 1'b1; a4 = 4'd0; b4 = 4'd9;
    @(negedge clk); start4 = 1'b0;
    n_cmp++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || p4 !== 8'd0) begin
      n_bad++;
      $display("FAIL zero_skip: done=%b busy=%b p=%0d, required done=1 busy=0 p=0", done4, busy4, p4);
    end
    @(negedge clk);
    n_cmp++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_skip_after: done=%b busy=%b, required 0 0", done4, busy4);
    end
    last_p4 = 8'd0;
`else
    op4(4'd0, 4'd9, 8'd0, "0x9");
`endif
  endtask

  task automatic test_start_ignored();
    @(negedge clk); start4 = 1'b1; a4 = 4'd5; b4 = 4'd3;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); start4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
    @(negedge clk); start4 = 1'b0;
    n_cmp++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_run: busy=%b done=%b, required 1 0", busy4, done4);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (done4 !== 1'b1 || p4 !== 8'd15) begin
      n_bad++;
      $display("FAIL ignore_result: done=%b p=%0d, required done=1 p=15", done4, p4);
    end
    last_p4 = 8'd15;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy4 !== 1'b0 || done4 !== 1'b0) begin
        n_bad++;
        $display("FAIL ignore_no_restart i=%0d: busy=%b done=%b, required 0 0", i, busy4, done4);
      end
    end
    op4(4'd7, 4'd7, 8'd49, "7x7");
  endtask

  task automatic test_async_reset();
    @(negedge clk); start4 = 1'b1; a4 = 4'd12; b4 = 4'd12;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'd0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b done=%b p=%0d, required 0 0 0", busy4, done4, p4);
    end
    last_p4 = 8'd0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done4 !== 1'b0 || busy4 !== 1'b0 || p4 !== 8'd0) begin
        n_bad++;
        $display("FAIL post_reset i=%0d: done=%b busy=%b p=%0d, required 0 0 0", i, done4, busy4, p4);
      end
    end
    op4(4'd3, 4'd4, 8'd12, "3x4");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] ev;
    int done_cnt = 0;
    int cyc = 0;
    int last_cyc = 0;
    @(negedge clk);
    a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
    exp_q.push_back(16'(a8) * 16'(b8));
    start8 = 1'b1;
    while (done_cnt < 200 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done8 === 1'b1) begin
        ev = exp_q.pop_front();
        n_cmp++;
        if (p8 !== ev) begin
          n_bad++;
          $display("FAIL b2b_product op=%0d: p=%0d, required %0d", done_cnt, p8, ev);
        end
        if (done_cnt > 0) begin
          n_cmp++;
          if (cyc - last_cyc != 10) begin
            n_bad++;
            $display("FAIL b2b_interval op=%0d: interval=%0d, required 10", done_cnt, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        done_cnt++;
        if (done_cnt < 200) begin
          a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
          exp_q.push_back(16'(a8) * 16'(b8));
        end else begin
          start8 = 1'b0;
        end
      end
    end
    n_cmp++;
    if (done_cnt != 200) begin
      n_bad++;
      $display("FAIL b2b_count: completed=%0d, required 200", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_max_and_hold();
    test_patterns();
    test_zero();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
